// File: rtl/conv_pkg.sv
// Shared types and default widths for the convolution MAC controller slice.
package conv_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Window address generator: walks a KSIZE x KSIZE window row by row, producing
// image addresses (base + row*IMG_W + col) and linear weight addresses.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int KSIZE      = 5,
    parameter int IMG_W      = 28,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(KSIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(KSIZE * KSIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_off_q, row_off_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    // The row counter is kept pre-scaled (row*IMG_W) so no multiplier is needed.
    always_comb begin
        base_d    = base_q;
        col_d     = col_q;
        row_off_d = row_off_q;
        idx_d     = idx_q;
        if (clear) begin
            base_d    = base;
            col_d     = '0;
            row_off_d = '0;
            idx_d     = '0;
        end else if (step) begin
            idx_d = idx_q + ONE;
            if (col_q == COL_LAST) begin
                col_d     = '0;
                row_off_d = row_off_q + ROW_STEP;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            col_q     <= '0;
            row_off_q <= '0;
            idx_q     <= '0;
        end else begin
            base_q    <= base_d;
            col_q     <= col_d;
            row_off_q <= row_off_d;
            idx_q     <= idx_d;
        end
    end

    assign img_addr = base_q + row_off_q + col_q;
    assign wgt_addr = idx_q;
    assign last     = (idx_q == IDX_LAST);

endmodule

// File: rtl/conv_mac_ctrl.sv
// Sequencer for one KSIZE x KSIZE floating-point window convolution: issues
// memory reads, drives an external MAC, captures and hands off the result.
module conv_mac_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int KSIZE      = 5,
    parameter int IMG_W      = 28,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] img_base,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] img_data,
    input  logic [DATA_WIDTH-1:0] wgt_data,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_start,
    input  logic [DATA_WIDTH-1:0] mac_c,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_valid,
    input  logic                  res_ready
);

    localparam int ELEMENTS = KSIZE * KSIZE;
    localparam int CNT_W    = $clog2(ELEMENTS + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(ELEMENTS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e state_q, state_d;

    logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  addr_clear;
    logic                  addr_step;
    logic                  addr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (go) state_d = ST_PRIME;
            ST_PRIME:   state_d = ST_RUN;
            ST_RUN:     if (run_cnt_q == RUN_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD:    if (res_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // RUN cycle k accumulates element k while reading element k+1.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        rd_en      = 1'b0;
        mac_start  = 1'b0;
        res_valid  = 1'b0;
        addr_clear = 1'b0;
        case (state_q)
            ST_IDLE:  addr_clear = go;
            ST_PRIME: rd_en = 1'b1;
            ST_RUN: begin
                mac_start = 1'b1;
                rd_en     = (run_cnt_q < RUN_LAST);
            end
            ST_HOLD:  res_valid = 1'b1;
            default:  ;
        endcase
    end

    // The address stays parked on the last element once it has been issued.
    assign addr_step = rd_en && !addr_last;

    always_comb begin
        run_cnt_d  = (state_q == ST_RUN) ? run_cnt_q + CNT_ONE : '0;
        res_data_d = (state_q == ST_CAPTURE) ? mac_c : res_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q  <= '0;
            res_data_q <= '0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            res_data_q <= res_data_d;
        end
    end

    conv_addr_gen #(
        .KSIZE      (KSIZE),
        .IMG_W      (IMG_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (addr_clear),
        .step     (addr_step),
        .base     (img_base),
        .img_addr (img_addr),
        .wgt_addr (wgt_addr),
        .last     (addr_last)
    );

    assign mac_a    = img_data;
    assign mac_b    = wgt_data;
    assign res_data = res_data_q;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl with behavioural memories and an FP
// accumulator standing in for the external datapath.
module tb_conv_mac_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int K    = 5;
    localparam int IW   = 28;
    localparam int ELEM = K * K;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [AW-1:0] img_base;
    logic          busy;
    logic [AW-1:0] img_addr;
    logic [AW-1:0] wgt_addr;
    logic          rd_en;
    logic [DW-1:0] img_data;
    logic [DW-1:0] wgt_data;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_start;
    logic [DW-1:0] mac_c;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] img_mem [0:(1<<AW)-1];
    logic [DW-1:0] wgt_mem [0:(1<<AW)-1];

    conv_mac_ctrl #(
        .DATA_WIDTH (DW),
        .KSIZE      (K),
        .IMG_W      (IW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .img_base  (img_base),
        .busy      (busy),
        .img_addr  (img_addr),
        .wgt_addr  (wgt_addr),
        .rd_en     (rd_en),
        .img_data  (img_data),
        .wgt_data  (wgt_data),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_start (mac_start),
        .mac_c     (mac_c),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = real'({1'b1, b[22:0]});
        e = int'(b[30:23]) - 150;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic s;
        int   e;
        real  m;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'(longint'((m - 1.0) * 8388608.0))};
    endfunction

    initial begin
        img_data = '0;
        wgt_data = '0;
        mac_c    = '0;
    end

    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            img_data <= img_mem[img_addr];
            wgt_data <= wgt_mem[wgt_addr];
        end
    end

    always @(posedge clk) begin
        if (mac_start === 1'b1) mac_c <= r2f(f2r(mac_c) + f2r(mac_a) * f2r(mac_b));
        else                    mac_c <= '0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [AW-1:0] base, input logic [31:0] iv, input logic [31:0] wv);
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) begin
            img_mem[i] = '0;
            wgt_mem[i] = '0;
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                a = AW'(int'(base) + r * IW + c);
                img_mem[a] = iv;
                wgt_mem[r * K + c] = wv;
            end
        end
    endtask

    typedef struct {
        logic [31:0]   img_val;
        logic [31:0]   wgt_val;
        logic [AW-1:0] base;
        int            hold_cycles;
        bit            go_in_run;
        bit            go_in_hold;
        logic [31:0]   exp_res;
    } vec_t;

    vec_t vecs [5];

    task automatic run_window(input vec_t v);
        int            cyc;
        int            first_valid;
        int            nrd;
        logic [AW-1:0] ia [$];
        logic [AW-1:0] wa [$];
        logic [AW-1:0] ea;
        load_mem(v.base, v.img_val, v.wgt_val);
        @(negedge clk);
        go       = 1'b1;
        img_base = v.base;
        @(posedge clk);
        @(negedge clk);
        go          = 1'b0;
        img_base    = ~v.base;
        cyc         = 0;
        first_valid = -1;
        chk("prime_busy", {31'd0, busy}, 32'd1);
        while (cyc < 60 && first_valid < 0) begin
            if (rd_en) begin
                ia.push_back(img_addr);
                wa.push_back(wgt_addr);
            end
            if (cyc == 1) chk("run_start_mac_c", mac_c, 32'd0);
            if (res_valid) begin
                first_valid = cyc;
            end else begin
                go = v.go_in_run && (cyc == 10);
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        go = 1'b0;
        if (first_valid < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL res_valid_timeout: got none within 60 cycles expected edge %0d", ELEM + 2);
            return;
        end
        chk("latency", 32'(first_valid), 32'(ELEM + 2));
        nrd = ia.size();
        chk("rd_count", 32'(nrd), 32'(ELEM));
        for (int n = 0; n < nrd && n < ELEM; n++) begin
            ea = AW'(int'(v.base) + (n / K) * IW + (n % K));
            chk("img_addr_seq", 32'(ia[n]), 32'(ea));
            chk("wgt_addr_seq", 32'(wa[n]), 32'(n));
        end
        for (int h = 0; h < v.hold_cycles; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd1);
            chk("hold_data", res_data, v.exp_res);
        end
        chk("res_data", res_data, v.exp_res);
        res_ready = 1'b1;
        go        = v.go_in_hold;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        go        = 1'b0;
        chk("post_accept_valid", {31'd0, res_valid}, 32'd0);
        chk("post_accept_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int acc_t [$];
        int prev_busy;
        int waited;

        vecs[0] = '{32'h3F800000, 32'h3F800000, 10'd0,    0,  1'b0, 1'b0, 32'h41C80000};
        vecs[1] = '{32'h40000000, 32'h3F000000, 10'd0,    10, 1'b0, 1'b0, 32'h41C80000};
        vecs[2] = '{32'h3F000000, 32'h3F000000, 10'd37,   1,  1'b1, 1'b1, 32'h40C80000};
        vecs[3] = '{32'h40000000, 32'h40000000, 10'd100,  2,  1'b0, 1'b0, 32'h42C80000};
        vecs[4] = '{32'hBF800000, 32'h3F800000, 10'd1000, 0,  1'b0, 1'b0, 32'hC1C80000};

        rst       = 1'b1;
        go        = 1'b0;
        img_base  = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_mac_start", {31'd0, mac_start}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_img_addr", 32'(img_addr), 32'd0);
        chk("rst_wgt_addr", 32'(wgt_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_window(vecs[i]);

        // Reset during the 10th RUN cycle abandons the window.
        load_mem(10'd0, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        go       = 1'b1;
        img_base = 10'd0;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_run_busy", {31'd0, busy}, 32'd1);
        chk("mid_run_mac_start", {31'd0, mac_start}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mac_start", {31'd0, mac_start}, 32'd0);
        chk("abort_rd_en", {31'd0, rd_en}, 32'd0);
        chk("abort_img_addr", 32'(img_addr), 32'd0);
        chk("abort_wgt_addr", 32'(wgt_addr), 32'd0);
        chk("abort_res_data", res_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_mac_c", mac_c, 32'd0);
        run_window(vecs[0]);

        // Back-to-back windows with go and res_ready held high.
        load_mem(10'd0, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        go        = 1'b1;
        res_ready = 1'b1;
        img_base  = 10'd0;
        prev_busy = int'(busy);
        for (int t = 0; t < 70; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && prev_busy == 0) acc_t.push_back(t);
            if (acc_t.size() > 0 && t == acc_t[acc_t.size() - 1] + 1)
                chk("b2b_run_start_mac_c", mac_c, 32'd0);
            if (res_valid) chk("b2b_res_data", res_data, 32'h41C80000);
            prev_busy = int'(busy);
        end
        go = 1'b0;
        if (acc_t.size() < 2) begin
            n_vec++;
            n_err++;
            $display("FAIL b2b_accepts: got %0d accepted starts expected at least 2", acc_t.size());
        end else begin
            for (int i = 1; i < acc_t.size(); i++)
                chk("b2b_go_to_go", 32'(acc_t[i] - acc_t[i - 1]), 32'(ELEM + 4));
        end
        waited = 0;
        while (busy && waited < 60) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        res_ready = 1'b0;
        chk("b2b_drain_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
